// File: rtl/exe_stage.sv
// LA32R execute stage: ALU / radix-2 restoring divider, data-SRAM request issue and forwarding info to ID.
// Holds one instruction; non-divide ops complete in the cycle they arrive.
//
// div_state | meaning
// ----------+---------------------------------------------------------------
// DIV_IDLE  | no divide in progress; a valid div op in ES starts one
// DIV_BUSY  | one restoring step per cycle, div_cnt counts iterations 0..31
// DIV_DONE  | quotient/remainder ready; held until MS accepts the result
module exe_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [164:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [77:0]  es_to_ms_bus,
  output logic [38:0]  es_to_ds_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITER - 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic          es_valid;
  logic [164:0]  es_bus;
  div_state_t    div_state;
  logic [CW-1:0] div_cnt;

  // st_inst = {st_w, st_h, st_b}; div_op = {mod_wu, div_wu, mod_w, div_w}
  logic [2:0]  st_inst;
  logic [4:0]  ld_inst;
  logic [3:0]  div_op;
  logic [14:0] alu_op;
  logic        load_op, src1_is_pc, src2_is_imm, gr_we, mem_we;
  logic [4:0]  dest;
  logic [31:0] imm, rj, rkd, pc;

  assign {st_inst, ld_inst, div_op, alu_op, load_op, src1_is_pc, src2_is_imm,
          gr_we, mem_we, dest, imm, rj, rkd, pc} = es_bus;

  logic is_div, es_ready_go;
  assign is_div         = |div_op;
  assign es_ready_go    = !is_div || (div_state == DIV_DONE);
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
  end

  // ALU; alu_op is one-hot: add sub slt sltu and nor or xor sll srl sra lui mul_w mulh_w mulh_wu
  logic [31:0] src1, src2, alu_result, sra_res, mulh_u;
  logic [63:0] smul;
  assign src1    = src1_is_pc ? pc : rj;
  assign src2    = src2_is_imm ? imm : rkd;
  assign sra_res = $signed(src1) >>> src2[4:0];
  assign smul    = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  // unsigned high word recovered from the signed product with one correction term per negative operand
  assign mulh_u  = smul[63:32] + (src1[31] ? src2 : 32'd0) + (src2[31] ? src1 : 32'd0);

  always_comb begin
    alu_result = 32'd0;
    if (alu_op[0])  alu_result = alu_result | (src1 + src2);
    if (alu_op[1])  alu_result = alu_result | (src1 - src2);
    if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
    if (alu_op[4])  alu_result = alu_result | (src1 & src2);
    if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
    if (alu_op[6])  alu_result = alu_result | (src1 | src2);
    if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
    if (alu_op[8])  alu_result = alu_result | (src1 << src2[4:0]);
    if (alu_op[9])  alu_result = alu_result | (src1 >> src2[4:0]);
    if (alu_op[10]) alu_result = alu_result | sra_res;
    if (alu_op[11]) alu_result = alu_result | src2;
    if (alu_op[12]) alu_result = alu_result | smul[31:0];
    if (alu_op[13]) alu_result = alu_result | smul[63:32];
    if (alu_op[14]) alu_result = alu_result | mulh_u;
  end

  // Divider works on magnitudes; signs are reapplied after the last step
  logic        div_signed;
  logic [31:0] div_quo, div_rem, div_dsr, div_dvd_raw;
  logic        div_neg_q, div_neg_r, div_zero;
  logic [32:0] div_shift, div_diff;

  assign div_signed = div_op[0] || div_op[1];
  assign div_shift  = {div_rem, div_quo[31]};
  assign div_diff   = div_shift - {1'b0, div_dsr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state   <= DIV_IDLE;
      div_cnt     <= '0;
      div_quo     <= 32'd0;
      div_rem     <= 32'd0;
      div_dsr     <= 32'd0;
      div_dvd_raw <= 32'd0;
      div_neg_q   <= 1'b0;
      div_neg_r   <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: if (es_valid && is_div) begin
          div_state   <= DIV_BUSY;
          div_cnt     <= '0;
          div_quo     <= (div_signed && rj[31]) ? -rj : rj;
          div_dsr     <= (div_signed && rkd[31]) ? -rkd : rkd;
          div_rem     <= 32'd0;
          div_dvd_raw <= rj;
          div_neg_q   <= div_signed && (rj[31] ^ rkd[31]);
          div_neg_r   <= div_signed && rj[31];
          div_zero    <= (rkd == 32'd0);
        end
        DIV_BUSY: begin
          div_quo <= {div_quo[30:0], ~div_diff[32]};
          div_rem <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_LAST) div_state <= DIV_DONE;
        end
        DIV_DONE: if (es_to_ms_valid && ms_allowin) div_state <= DIV_IDLE;
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  logic [31:0] div_q_fix, div_r_fix, div_result, es_result;
  assign div_q_fix  = div_zero ? 32'hFFFF_FFFF : (div_neg_q ? -div_quo : div_quo);
  assign div_r_fix  = div_zero ? div_dvd_raw : (div_neg_r ? -div_rem : div_rem);
  assign div_result = (div_op[0] || div_op[2]) ? div_q_fix : div_r_fix;
  assign es_result  = is_div ? div_result : alu_result;

  // Memory request
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  assign data_sram_addr = rj + imm;

  always_comb begin
    st_mask = 4'b0000;
    st_data = rkd;
    if (st_inst[0]) begin
      st_mask = 4'b0001 << data_sram_addr[1:0];
      st_data = {4{rkd[7:0]}};
    end else if (st_inst[1]) begin
      st_mask = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      st_data = {2{rkd[15:0]}};
    end else if (st_inst[2]) begin
      st_mask = 4'b1111;
    end
  end

  assign data_sram_en    = es_valid && (load_op || mem_we) && ms_allowin;
  assign data_sram_we    = (es_valid && mem_we) ? st_mask : 4'b0000;
  assign data_sram_wdata = st_data;

  logic es_we, es_load;
  assign es_we   = es_valid && gr_we;
  // a divide still in flight looks like a load to ID so it stalls rather than forwards
  assign es_load = es_valid && gr_we && (load_op || (is_div && div_state != DIV_DONE));

  assign es_to_ms_bus = {ld_inst, data_sram_addr[1:0], load_op, gr_we, dest, es_result, pc};
  assign es_to_ds_bus = {es_we, dest, es_result, es_load};

endmodule
